// File: rtl/mtm_alu_serializer_pkg.sv
// Shared framing definitions for the ALU serial link (serializer and deserializer).
package mtm_alu_serializer_pkg;

  // Bit-level frame states.
  // state    | meaning
  // ST_IDLE  | line idle high, no frame in flight
  // ST_START | start bit (0) on the wire
  // ST_TYPE  | type bit on the wire (0 = data, 1 = cmd)
  // ST_DATA  | payload bit bit_cnt on the wire, MSB first (7..0)
  // ST_STOP  | stop bit (1) on the wire
  // ST_GAP   | inter-frame idle bits (1) between frames of one packet
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_TYPE  = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4,
    ST_GAP   = 3'd5
  } state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic TYPE_DATA  = 1'b0;
  localparam logic TYPE_CMD   = 1'b1;
  localparam int   FRAME_BITS = 11;

endpackage

// File: rtl/mtm_alu_serializer_if.sv
// Request bus between the ALU output register and the serializer.
interface mtm_alu_serializer_if;
  logic [31:0] C;
  logic [7:0]  CTL;
  logic        valid;
  logic        ready;

  modport master (output C, output CTL, output valid, input ready);
  modport slave  (input C, input CTL, input valid, output ready);
endinterface

// File: rtl/mtm_alu_serializer_frame_tx.sv
// Sends one 11-bit frame {start, type, byte MSB-first, stop}; can chain the
// next frame without an idle bit when the caller has more to send.
module mtm_alu_serializer_frame_tx
  import mtm_alu_serializer_pkg::*;
#(
  parameter int IFG_BITS = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,     // load {type_i, byte_i} on this edge (only when next_ok_o)
  input  logic       more_i,      // caller has another frame queued after this one
  input  logic       type_i,
  input  logic [7:0] byte_i,
  output logic       sout_o,
  output logic       next_ok_o,   // a new frame may start on this edge
  output logic       last_bit_o   // this bit-time is the final one of the current frame
);

  state_e     st_q;
  logic [7:0] byte_q;
  logic       type_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] gap_cnt_q;
  logic       sout_q;

  // The stop bit ends the frame unless an inter-frame gap must follow it.
  assign last_bit_o = ((st_q == ST_STOP) && ((IFG_BITS == 0) || !more_i)) ||
                      ((st_q == ST_GAP) && (gap_cnt_q == 8'd0));
  assign next_ok_o  = (st_q == ST_IDLE) || last_bit_o;
  assign sout_o     = sout_q;

  // Frame FSM; sout_q is loaded with the bit belonging to the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= ST_IDLE;
      byte_q    <= 8'd0;
      type_q    <= TYPE_DATA;
      bit_cnt_q <= 3'd0;
      gap_cnt_q <= 8'd0;
      sout_q    <= STOP_BIT;
    end else if (next_ok_o) begin
      if (start_i) begin
        st_q   <= ST_START;
        byte_q <= byte_i;
        type_q <= type_i;
        sout_q <= START_BIT;
      end else begin
        st_q   <= ST_IDLE;
        sout_q <= STOP_BIT;
      end
    end else begin
      case (st_q)
        ST_START: begin
          st_q   <= ST_TYPE;
          sout_q <= type_q;
        end
        ST_TYPE: begin
          st_q      <= ST_DATA;
          bit_cnt_q <= 3'd7;
          sout_q    <= byte_q[7];
          byte_q    <= {byte_q[6:0], 1'b0};
        end
        ST_DATA: begin
          if (bit_cnt_q == 3'd0) begin
            st_q   <= ST_STOP;
            sout_q <= STOP_BIT;
          end else begin
            bit_cnt_q <= bit_cnt_q - 3'd1;
            sout_q    <= byte_q[7];
            byte_q    <= {byte_q[6:0], 1'b0};
          end
        end
        ST_STOP: begin
          // Only reached with a frame queued and a non-zero gap.
          st_q      <= ST_GAP;
          gap_cnt_q <= 8'(IFG_BITS - 1);
          sout_q    <= STOP_BIT;
        end
        ST_GAP: begin
          gap_cnt_q <= gap_cnt_q - 8'd1;
          sout_q    <= STOP_BIT;
        end
        default: begin
          st_q   <= ST_IDLE;
          sout_q <= STOP_BIT;
        end
      endcase
    end
  end

endmodule

// File: rtl/mtm_alu_serializer.sv
// ALU serial-link transmitter: packetizes {C, CTL} into data frames (C, MSB
// byte first) followed by one cmd frame, or a lone cmd frame for errors.
module mtm_alu_serializer
  import mtm_alu_serializer_pkg::*;
#(
  parameter int N_DATA_BYTES = 4,
  parameter int IFG_BITS     = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mtm_alu_serializer_if.slave   bus,
  output logic                  sout,
  output logic                  busy,
  output logic                  done
);

  localparam int BC_W = (N_DATA_BYTES > 1) ? $clog2(N_DATA_BYTES) : 1;
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(N_DATA_BYTES - 1);

  logic            active_q;
  logic [31:0]     c_sh_q;       // C shadow, shifted left one byte per data frame
  logic [7:0]      ctl_q;
  logic [BC_W-1:0] byte_cnt_q;
  logic            data_done_q;  // all data frames issued, cmd frame is next
  logic            cmd_sent_q;   // cmd frame issued, packet ends after it
  logic            done_q;

  logic       more;
  logic       sel_cmd;
  logic       frm_start;
  logic       frm_next_ok;
  logic       frm_last_bit;
  logic       pkt_end;
  logic       accept;
  logic       frm_type;
  logic [7:0] frm_byte;

  // A new request may be taken while the final stop bit is on the wire, so a
  // held valid restarts on the same edge that raises done.
  assign more      = active_q && !cmd_sent_q;
  assign sel_cmd   = ctl_q[7] || data_done_q;
  assign frm_start = more && frm_next_ok;
  assign pkt_end   = active_q && cmd_sent_q && frm_last_bit;
  assign bus.ready = !active_q || pkt_end;
  assign accept    = bus.valid && bus.ready;
  assign frm_type  = sel_cmd ? TYPE_CMD : TYPE_DATA;
  assign frm_byte  = sel_cmd ? ctl_q : c_sh_q[31:24];

  assign busy = active_q;
  assign done = done_q;

  // Packet sequencing: shadow capture on accept, byte selection per frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q    <= 1'b0;
      c_sh_q      <= 32'd0;
      ctl_q       <= 8'd0;
      byte_cnt_q  <= '0;
      data_done_q <= 1'b0;
      cmd_sent_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= pkt_end;
      if (accept) begin
        active_q    <= 1'b1;
        c_sh_q      <= bus.C;
        ctl_q       <= bus.CTL;
        byte_cnt_q  <= '0;
        data_done_q <= 1'b0;
        cmd_sent_q  <= 1'b0;
      end else if (pkt_end) begin
        active_q <= 1'b0;
      end else if (frm_start) begin
        if (sel_cmd) begin
          cmd_sent_q <= 1'b1;
        end else begin
          c_sh_q <= {c_sh_q[23:0], 8'd0};
          if (byte_cnt_q == BC_LAST) begin
            byte_cnt_q  <= '0;
            data_done_q <= 1'b1;
          end else begin
            byte_cnt_q <= byte_cnt_q + 1'b1;
          end
        end
      end
    end
  end

  mtm_alu_serializer_frame_tx #(
    .IFG_BITS (IFG_BITS)
  ) u_frame_tx (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (frm_start),
    .more_i     (more),
    .type_i     (frm_type),
    .byte_i     (frm_byte),
    .sout_o     (sout),
    .next_ok_o  (frm_next_ok),
    .last_bit_o (frm_last_bit)
  );

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// Directed bench for the ALU serial-link transmitter.
module tb_mtm_alu_serializer;

  logic clk = 1'b0;
  logic rst_n;
  logic sout, busy, done;
  int   n_checks = 0;
  int   n_errors = 0;

  mtm_alu_serializer_if bus ();

  mtm_alu_serializer #(
    .N_DATA_BYTES (4),
    .IFG_BITS     (0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .sout  (sout),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line image of one packet, first bit in the MSB of the used length.
  function automatic void build(input logic [31:0] c, input logic [7:0] ctl,
                                output logic [54:0] bits, output int len);
    if (ctl[7]) begin
      bits = {44'd0, 1'b0, 1'b1, ctl, 1'b1};
      len  = 11;
    end else begin
      bits = {1'b0, 1'b0, c[31:24], 1'b1, 1'b0, 1'b0, c[23:16], 1'b1,
              1'b0, 1'b0, c[15:8],  1'b1, 1'b0, 1'b0, c[7:0],   1'b1,
              1'b0, 1'b1, ctl, 1'b1};
      len  = 55;
    end
  endfunction

  // Present a request and let the next edge accept it.
  task automatic accept(input logic [31:0] c, input logic [7:0] ctl, input logic hold);
    bus.C     = c;
    bus.CTL   = ctl;
    bus.valid = 1'b1;
    tick();
    if (!hold) bus.valid = 1'b0;
    check("accept_busy", busy, 1'b1);
    check("accept_ready", bus.ready, 1'b0);
    check("accept_sout_idle", sout, 1'b1);
  endtask

  // Sample n bit-times; optionally churn the inputs during the first part.
  task automatic capture(input int n, input logic churn,
                         output logic [54:0] bits, output int rdy_hi, output int done_hi);
    bits    = '0;
    rdy_hi  = 0;
    done_hi = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      bits = {bits[53:0], sout};
      if (i < n - 1 && bus.ready) rdy_hi++;
      if (done) done_hi++;
      if (churn) begin
        if (i < n - 8) begin
          bus.C     = $urandom;
          bus.CTL   = 8'($urandom);
          bus.valid = 1'($urandom_range(0, 1));
        end else begin
          bus.valid = 1'b0;
        end
      end
    end
  endtask

  initial begin
    logic [54:0] got, exp;
    int          len, rdy_hi, done_hi;
    logic [31:0] rc;
    logic [7:0]  rctl;

    rst_n     = 1'b0;
    bus.C     = 32'd0;
    bus.CTL   = 8'd0;
    bus.valid = 1'b0;
    #12;
    check("rst_sout", sout, 1'b1);
    check("rst_ready", bus.ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    #5 rst_n = 1'b1;
    tick();
    check("idle_sout", sout, 1'b1);
    check("idle_ready", bus.ready, 1'b1);

    // 1: normal packet
    accept(32'hDEADBEEF, 8'h0A, 1'b0);
    capture(55, 1'b0, got, rdy_hi, done_hi);
    exp = {1'b0, 1'b0, 8'b11011110, 1'b1, 1'b0, 1'b0, 8'b10101101, 1'b1,
           1'b0, 1'b0, 8'b10111110, 1'b1, 1'b0, 1'b0, 8'b11101111, 1'b1,
           1'b0, 1'b1, 8'b00001010, 1'b1};
    check("norm_bits", got, exp);
    check("norm_ready_low", rdy_hi, 0);
    check("norm_no_early_done", done_hi, 0);
    tick();
    check("norm_done", done, 1'b1);
    check("norm_busy_end", busy, 1'b0);
    check("norm_ready_end", bus.ready, 1'b1);
    check("norm_sout_end", sout, 1'b1);
    tick();
    check("norm_done_pulse", done, 1'b0);

    // 2: error packet, cmd frame only
    accept(32'h12345678, 8'hC9, 1'b0);
    capture(11, 1'b0, got, rdy_hi, done_hi);
    check("err_bits", got, {44'd0, 1'b0, 1'b1, 8'b11001001, 1'b1});
    check("err_no_early_done", done_hi, 0);
    tick();
    check("err_done", done, 1'b1);
    check("err_busy_end", busy, 1'b0);

    // 3: back-to-back with valid held
    accept(32'h11223344, 8'h05, 1'b1);
    bus.C   = 32'hCAFEF00D;
    bus.CTL = 8'h3C;
    capture(55, 1'b0, got, rdy_hi, done_hi);
    build(32'h11223344, 8'h05, exp, len);
    check("b2b_first_bits", got, exp);
    check("b2b_first_ready_low", rdy_hi, 0);
    tick();
    bus.valid = 1'b0;
    check("b2b_done", done, 1'b1);
    check("b2b_gap_sout", sout, 1'b1);
    check("b2b_rebusy", busy, 1'b1);
    check("b2b_ready_low", bus.ready, 1'b0);
    capture(55, 1'b0, got, rdy_hi, done_hi);
    check("b2b_second_bits", got,
          {1'b0, 1'b0, 8'hCA, 1'b1, 1'b0, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0, 8'hF0, 1'b1,
           1'b0, 1'b0, 8'h0D, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b1});
    check("b2b_second_ready_low", rdy_hi, 0);
    tick();
    check("b2b_second_done", done, 1'b1);
    check("b2b_second_idle", busy, 1'b0);

    // 4: input churn while busy
    accept(32'h01234567, 8'h12, 1'b0);
    capture(55, 1'b1, got, rdy_hi, done_hi);
    build(32'h01234567, 8'h12, exp, len);
    check("churn_bits", got, exp);
    check("churn_no_early_done", done_hi, 0);
    tick();
    check("churn_done", done, 1'b1);
    check("churn_idle", busy, 1'b0);
    tick();

    // 5: reset during bit 20 (a data 0 of byte AD)
    accept(32'hDEADBEEF, 8'h0A, 1'b0);
    capture(19, 1'b0, got, rdy_hi, done_hi);
    @(posedge clk);
    #3;
    check("pre_rst_sout", sout, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_sout", sout, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_ready", bus.ready, 1'b1);
    #3 rst_n = 1'b1;
    tick();
    check("postrst_ready", bus.ready, 1'b1);
    check("postrst_sout", sout, 1'b1);
    check("postrst_done", done, 1'b0);
    accept(32'h00000001, 8'h00, 1'b0);
    capture(55, 1'b0, got, rdy_hi, done_hi);
    check("postrst_bits", got,
          {1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1,
           1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1});
    tick();
    check("postrst_pkt_done", done, 1'b1);

    // 6: random packets against the frame model
    for (int p = 0; p < 8; p++) begin
      rc   = $urandom;
      rctl = 8'($urandom);
      build(rc, rctl, exp, len);
      accept(rc, rctl, 1'b0);
      capture(len, 1'b0, got, rdy_hi, done_hi);
      check("rand_bits", got, exp);
      tick();
      check("rand_done", done, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
